// File: rtl/ckdiv_glitchfree.sv
// Glitch-free programmable clock divider: registered out_clk whose ratio, start and stop
// are adopted only on a full output-period boundary.
module ckdiv_glitchfree #(
  parameter int unsigned DIV_W    = 8,
  parameter bit          ODD_HIGH = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             out_clk,
  output logic             active,
  output logic [DIV_W-1:0] cur_div,
  output logic             switch_ack
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             out_clk_q, out_clk_d;
  logic             active_q, active_d;
  logic             ack_q, ack_d;

  logic             req_valid_c;
  logic             boundary_c;
  logic [DIV_W-1:0] req_div_c;
  logic [DIV_W-1:0] cnt_inc_c;
  logic [DIV_W-1:0] high_len_c;

  assign req_valid_c = en && (div != '0);
  assign req_div_c   = (div == DIV_W'(1)) ? DIV_W'(2) : div;
  assign cnt_inc_c   = cnt_q + DIV_W'(1);
  // Odd ratios: the spare cycle goes to the high phase only when ODD_HIGH is set.
  assign high_len_c  = (cur_div_q >> 1) + DIV_W'(cur_div_q[0] & ODD_HIGH);
  assign boundary_c  = (cnt_q == cur_div_q - DIV_W'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    out_clk_d = out_clk_q;
    active_d  = active_q;
    ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        out_clk_d = 1'b0;
        if (req_valid_c) begin
          state_d   = RUN;
          cnt_d     = '0;
          cur_div_d = req_div_c;
          out_clk_d = 1'b1;
          active_d  = 1'b1;
          ack_d     = 1'b1;
        end
      end
      RUN: begin
        if (!boundary_c) begin
          cnt_d     = cnt_inc_c;
          out_clk_d = (cnt_inc_c < high_len_c);
        end else if (req_valid_c) begin
          cnt_d     = '0;
          out_clk_d = 1'b1;
          cur_div_d = req_div_c;
          ack_d     = (req_div_c != cur_div_q);
        end else begin
          state_d   = IDLE;
          cnt_d     = '0;
          out_clk_d = 1'b0;
          cur_div_d = '0;
          active_d  = 1'b0;
          ack_d     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_div_q <= '0;
      out_clk_q <= 1'b0;
      active_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      out_clk_q <= out_clk_d;
      active_q  <= active_d;
      ack_q     <= ack_d;
    end
  end

  assign out_clk    = out_clk_q;
  assign active     = active_q;
  assign cur_div    = cur_div_q;
  assign switch_ack = ack_q;

endmodule

// File: tb/tb_ckdiv_glitchfree.sv
// Bench for ckdiv_glitchfree: two instances (ODD_HIGH=1 and 0) share stimulus and are
// compared every cycle against a phase-length reference model.
module tb_ckdiv_glitchfree;
  localparam int unsigned DIV_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             out_a, act_a, ack_a;
  logic             out_b, act_b, ack_b;
  logic [DIV_W-1:0] cur_a, cur_b;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = ODD_HIGH=1 instance, 1 = ODD_HIGH=0 instance
  bit          m_run [2];
  int unsigned m_cur [2];
  bit          m_out [2];
  bit          m_ack [2];
  int unsigned m_hi  [2];
  int unsigned m_lo  [2];

  ckdiv_glitchfree #(.DIV_W(DIV_W), .ODD_HIGH(1'b1)) u_a (
    .CLK(CLK), .RST(RST), .en(en), .div(div),
    .out_clk(out_a), .active(act_a), .cur_div(cur_a), .switch_ack(ack_a)
  );

  ckdiv_glitchfree #(.DIV_W(DIV_W), .ODD_HIGH(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .en(en), .div(div),
    .out_clk(out_b), .active(act_b), .cur_div(cur_b), .switch_ack(ack_b)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned high_len(input int unsigned d, input bit odd_high);
    if (d % 2 == 0) return d / 2;
    return odd_high ? (d + 1) / 2 : (d - 1) / 2;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_run[m] = 0; m_cur[m] = 0; m_out[m] = 0; m_ack[m] = 0; m_hi[m] = 0; m_lo[m] = 0;
    end
  endtask

  task automatic model_start_period(input int m, input int unsigned d);
    m_cur[m] = d;
    m_hi[m]  = high_len(d, m == 0);
    m_lo[m]  = d - m_hi[m];
  endtask

  task automatic model_emit(input int m);
    if (m_hi[m] > 0) begin m_out[m] = 1; m_hi[m]--; end
    else begin m_out[m] = 0; m_lo[m]--; end
  endtask

  task automatic model_edge(input int m);
    int unsigned d;
    bit v;
    d = (div == 1) ? 2 : int'(div);
    v = en && (div != 0);
    if (RST) begin
      m_run[m] = 0; m_cur[m] = 0; m_out[m] = 0; m_ack[m] = 0; m_hi[m] = 0; m_lo[m] = 0;
    end else if (!m_run[m]) begin
      if (v) begin
        m_run[m] = 1; m_ack[m] = 1;
        model_start_period(m, d);
        model_emit(m);
      end else begin
        m_out[m] = 0; m_ack[m] = 0;
      end
    end else if (m_hi[m] + m_lo[m] == 0) begin
      if (v) begin
        m_ack[m] = (d != m_cur[m]);
        model_start_period(m, d);
        model_emit(m);
      end else begin
        m_run[m] = 0; m_cur[m] = 0; m_out[m] = 0; m_ack[m] = 1;
      end
    end else begin
      model_emit(m);
      m_ack[m] = 0;
    end
  endtask

  task automatic compare_all();
    check("out_a", 32'(out_a), 32'(m_out[0]));
    check("act_a", 32'(act_a), 32'(m_run[0]));
    check("cur_a", 32'(cur_a), m_cur[0]);
    check("ack_a", 32'(ack_a), 32'(m_ack[0]));
    check("out_b", 32'(out_b), 32'(m_out[1]));
    check("act_b", 32'(act_b), 32'(m_run[1]));
    check("cur_b", 32'(cur_b), m_cur[1]);
    check("ack_b", 32'(ack_b), 32'(m_ack[1]));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int acks;
    int hi_len;
    int lo_len;
    int guard;

    RST = 1'b1; en = 1'b0; div = '0;
    model_reset();
    #12;
    compare_all();
    RST = 1'b0;
    steps(2);

    // start at ratio 3: 1,1,0 on the ODD_HIGH=1 instance
    en = 1'b1; div = DIV_W'(3);
    step();
    check("start_ack", 32'(ack_a), 32'd1);
    check("start_cur", 32'(cur_a), 32'd3);
    check("start_out", 32'(out_a), 32'd1);
    steps(8);

    // ratio switch 4 -> 2 requested mid-period
    div = DIV_W'(4);
    steps(9);
    div = DIV_W'(2);
    acks = 0;
    for (int i = 0; i < 8; i++) begin step(); acks += int'(ack_a); end
    check("switch_ack_count", 32'(acks), 32'd1);

    // stop right after ratio 6 is adopted (cnt=0)
    div = DIV_W'(6);
    guard = 0;
    do begin step(); guard++; end while (!(ack_a && cur_a == DIV_W'(6)) && guard < 20);
    check("adopt6_seen", 32'(cur_a), 32'd6);
    en = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin step(); acks += int'(ack_a); end
    check("stop_ack_count", 32'(acks), 32'd1);
    check("stop_active", 32'(act_a), 32'd0);
    check("stop_cur", 32'(cur_a), 32'd0);
    check("stop_out", 32'(out_a), 32'd0);

    // div=1 behaves as 2; div=0 never starts
    en = 1'b1; div = DIV_W'(1);
    steps(6);
    check("div1_cur", 32'(cur_a), 32'd2);
    div = '0;
    steps(6);
    check("div0_idle", 32'(act_a), 32'd0);

    // ratio 255, ODD_HIGH=0: high 127, low 128
    div = DIV_W'(255);
    step();
    hi_len = 0; lo_len = 0; guard = 0;
    while (out_b && guard < 300) begin hi_len++; step(); guard++; end
    while (!out_b && guard < 600) begin lo_len++; step(); guard++; end
    check("hi255_b", 32'(hi_len), 32'd127);
    check("lo255_b", 32'(lo_len), 32'd128);
    steps(20);

    // async reset in the middle of a high phase
    div = DIV_W'(8);
    steps(260);
    guard = 0;
    while (!out_a && guard < 20) begin step(); guard++; end
    check("pre_rst_high", 32'(out_a), 32'd1);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    compare_all();
    step();
    #2;
    RST = 1'b0; div = DIV_W'(2);
    steps(8);

    // rewrite same ratio on boundaries: no acks
    div = DIV_W'(5);
    steps(12);
    div = DIV_W'(5);
    acks = 0;
    for (int i = 0; i < 15; i++) begin step(); acks += int'(ack_a) + int'(ack_b); end
    check("same_value_acks", 32'(acks), 32'd0);

    // random en/div activity
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        en  = ($urandom_range(0, 7) != 0);
        div = DIV_W'($urandom_range(0, 9));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
